// File: rtl/program_encoder.sv
// program_encoder: appends one block (length, address hi/lo, type, payload)
// at the current write pointer of a byte-wide program RAM.
module program_encoder #(
    parameter int PROGRAM_SIZE        = 64,
    parameter int DATA_BLOCK_MAX_SIZE = 32,
    parameter int PROG_ADDR_BITS      = $clog2(PROGRAM_SIZE)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [7:0]                block_length,
    input  logic [15:0]               block_address,
    input  logic [7:0]                block_type,
    input  logic [7:0]                block_data [DATA_BLOCK_MAX_SIZE],
    output logic                      ready,
    output logic                      done,
    output logic                      error,
    output logic                      prog_we,
    output logic [PROG_ADDR_BITS-1:0] prog_addr,
    output logic [7:0]                prog_wdata,
    output logic [PROG_ADDR_BITS:0]   prog_used
);

    localparam int IDX_W = (DATA_BLOCK_MAX_SIZE > 1) ? $clog2(DATA_BLOCK_MAX_SIZE) : 1;
    // Fit check width: wide enough that used + 4 + 255 can never wrap.
    localparam int CW    = (PROG_ADDR_BITS + 2 > 10) ? PROG_ADDR_BITS + 2 : 10;
    localparam int UW    = PROG_ADDR_BITS + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_HDR_LEN, S_HDR_AHI, S_HDR_ALO, S_HDR_TYPE, S_DATA, S_FIN
    } state_t;

    state_t                    state_q, state_d;
    logic [7:0]                idx_q, idx_d;
    logic                      err_q, err_d;
    logic [UW-1:0]             prog_used_q, prog_used_d;
    logic                      ready_q, ready_d;
    logic                      done_q, done_d;
    logic                      error_q, error_d;
    logic                      prog_we_q, prog_we_d;
    logic [PROG_ADDR_BITS-1:0] prog_addr_q, prog_addr_d;
    logic [7:0]                prog_wdata_q, prog_wdata_d;

    logic [7:0]                len_q;
    logic [15:0]               addr_q;
    logic [7:0]                btype_q;
    logic [7:0]                data_q [DATA_BLOCK_MAX_SIZE];

    logic                      accept;
    logic [CW-1:0]             need_w;
    logic                      chk_fail;

    assign accept   = (state_q == S_IDLE) && start;
    assign need_w   = CW'(prog_used_q) + CW'(4) + CW'(len_q);
    assign chk_fail = (CW'(len_q) > CW'(DATA_BLOCK_MAX_SIZE)) || (need_w > CW'(PROGRAM_SIZE));

    // Capture the request header fields so later input changes cannot disturb it.
    always_ff @(posedge clk) begin
        if (accept) begin
            len_q   <= block_length;
            addr_q  <= block_address;
            btype_q <= block_type;
        end
    end

    // Capture the payload bytes, one register per slot.
    generate
        for (genvar gi = 0; gi < DATA_BLOCK_MAX_SIZE; gi++) begin : g_data
            // Payload slot gi is loaded on acceptance only.
            always_ff @(posedge clk) begin
                if (accept) begin
                    data_q[gi] <= block_data[gi];
                end
            end
        end
    endgenerate

    // State register and registered outputs; reset aborts any request in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            idx_q        <= 8'd0;
            err_q        <= 1'b0;
            prog_used_q  <= '0;
            ready_q      <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            prog_we_q    <= 1'b0;
            prog_addr_q  <= '0;
            prog_wdata_q <= 8'd0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            err_q        <= err_d;
            prog_used_q  <= prog_used_d;
            ready_q      <= ready_d;
            done_q       <= done_d;
            error_q      <= error_d;
            prog_we_q    <= prog_we_d;
            prog_addr_q  <= prog_addr_d;
            prog_wdata_q <= prog_wdata_d;
        end
    end

    // Next-state logic: walk header bytes then payload; the pointer advances after each write.
    always_comb begin
        state_d     = state_q;
        idx_d       = 8'd0;
        err_d       = err_q;
        prog_used_d = prog_used_q + UW'(prog_we_q);
        unique case (state_q)
            S_IDLE: begin
                err_d = 1'b0;
                if (start) state_d = S_CHECK;
            end
            S_CHECK: begin
                err_d   = chk_fail;
                state_d = chk_fail ? S_FIN : S_HDR_LEN;
            end
            S_HDR_LEN:  state_d = S_HDR_AHI;
            S_HDR_AHI:  state_d = S_HDR_ALO;
            S_HDR_ALO:  state_d = S_HDR_TYPE;
            S_HDR_TYPE: state_d = (len_q == 8'd0) ? S_FIN : S_DATA;
            S_DATA: begin
                if (idx_q == len_q - 8'd1) begin
                    state_d = S_FIN;
                end else begin
                    state_d = S_DATA;
                    idx_d   = idx_q + 8'd1;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: decode the upcoming state so every output comes straight from a flop.
    always_comb begin
        ready_d      = (state_d == S_IDLE);
        done_d       = (state_d == S_FIN);
        error_d      = (state_d == S_FIN) && err_d;
        prog_we_d    = 1'b0;
        prog_addr_d  = prog_used_d[PROG_ADDR_BITS-1:0];
        prog_wdata_d = 8'd0;
        unique case (state_d)
            S_HDR_LEN:  begin prog_we_d = 1'b1; prog_wdata_d = len_q;         end
            S_HDR_AHI:  begin prog_we_d = 1'b1; prog_wdata_d = addr_q[15:8];  end
            S_HDR_ALO:  begin prog_we_d = 1'b1; prog_wdata_d = addr_q[7:0];   end
            S_HDR_TYPE: begin prog_we_d = 1'b1; prog_wdata_d = btype_q;       end
            S_DATA:     begin prog_we_d = 1'b1; prog_wdata_d = data_q[idx_d[IDX_W-1:0]]; end
            default:    begin prog_we_d = 1'b0; end
        endcase
    end

    assign ready      = ready_q;
    assign done       = done_q;
    assign error      = error_q;
    assign prog_we    = prog_we_q;
    assign prog_addr  = prog_addr_q;
    assign prog_wdata = prog_wdata_q;
    assign prog_used  = prog_used_q;

endmodule

// File: tb/tb_program_encoder.sv
// tb_program_encoder: directed blocks against a byte-list model of the image format.
module tb_program_encoder;

    localparam int PSIZE = 64;
    localparam int MAXB  = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  block_length;
    logic [15:0] block_address;
    logic [7:0]  block_type;
    logic [7:0]  block_data [MAXB];
    logic        ready, done, error, prog_we;
    logic [5:0]  prog_addr;
    logic [7:0]  prog_wdata;
    logic [6:0]  prog_used;

    always #5 clk = ~clk;

    program_encoder #(.PROGRAM_SIZE(PSIZE), .DATA_BLOCK_MAX_SIZE(MAXB)) dut (
        .clk(clk), .rst(rst), .start(start),
        .block_length(block_length), .block_address(block_address),
        .block_type(block_type), .block_data(block_data),
        .ready(ready), .done(done), .error(error),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata),
        .prog_used(prog_used)
    );

    typedef struct packed {
        logic       ready;
        logic       done;
        logic       error;
        logic       we;
        logic [5:0] addr;
        logic [7:0] wdata;
        logic [6:0] used;
    } exp_t;

    exp_t       exp_q[$];
    int         model_used;
    int         checks;
    int         failures;
    int         ncyc;
    int         done_cyc;
    logic       done_err;
    int         done_cnt;
    int         wr_count;
    logic [7:0] ram [PSIZE];

    function automatic exp_t mk(input logic r, input logic d, input logic e, input logic w,
                                input int a, input int wd, input int u);
        exp_t x;
        x.ready = r; x.done = d; x.error = e; x.we = w;
        x.addr = 6'(a); x.wdata = 8'(wd); x.used = 7'(u);
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
        end
    endtask

    // Model: a request is the byte list L, addr_hi, addr_lo, type, data..., laid at the pointer.
    task automatic model_request(input int len, input logic [15:0] a, input logic [7:0] t,
                                 input logic [7:0] base);
        int         need;
        bit         ok;
        logic [7:0] bytes[$];
        need = model_used + 4 + len;
        ok   = (len <= MAXB) && (need <= PSIZE);
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, model_used));
        if (ok) begin
            bytes.push_back(8'(len));
            bytes.push_back(a[15:8]);
            bytes.push_back(a[7:0]);
            bytes.push_back(t);
            for (int i = 0; i < len; i++) bytes.push_back(base + 8'(i));
            for (int k = 0; k < bytes.size(); k++)
                exp_q.push_back(mk(0, 0, 0, 1, model_used + k, bytes[k], model_used + k));
            model_used = need;
        end
        exp_q.push_back(mk(0, 1, !ok, 0, 0, 0, model_used));
    endtask

    // Per-cycle compare against the model trace; idle expectations when no request is pending.
    task automatic compare_loop();
        exp_t e;
        @(posedge clk);
        forever begin
            @(negedge clk);
            ncyc++;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else                  e = mk(1, 0, 0, 0, 0, 0, model_used);
            if (prog_we === 1'b1) begin
                ram[prog_addr] = prog_wdata;
                wr_count++;
            end
            if (done === 1'b1) begin
                done_cyc = ncyc;
                done_err = error;
                done_cnt++;
            end
            checks++;
            if ({ready, done, error, prog_we, prog_used} !== {e.ready, e.done, e.error, e.we, e.used} ||
                (e.we && ({prog_addr, prog_wdata} !== {e.addr, e.wdata}))) begin
                failures++;
                $display("FAIL trace cyc=%0d got rdy=%b done=%b err=%b we=%b addr=%0d wdata=%h used=%0d, expected rdy=%b done=%b err=%b we=%b addr=%0d wdata=%h used=%0d",
                         ncyc, ready, done, error, prog_we, prog_addr, prog_wdata, prog_used,
                         e.ready, e.done, e.error, e.we, e.addr, e.wdata, e.used);
            end
        end
    endtask

    // Issue one request (call just after a posedge); inputs are scrambled once accepted.
    task automatic run_block(input int len, input logic [15:0] a, input logic [7:0] t,
                             input logic [7:0] base, output int lat, output logic err);
        int t0;
        #1;
        start = 1'b1; block_length = 8'(len); block_address = a; block_type = t;
        for (int i = 0; i < MAXB; i++) block_data[i] = base + 8'(i);
        @(posedge clk);
        t0 = ncyc;
        model_request(len, a, t, base);
        #1;
        start = 1'b0; block_length = 8'($urandom); block_address = 16'($urandom);
        block_type = 8'($urandom);
        for (int i = 0; i < MAXB; i++) block_data[i] = 8'($urandom);
        for (int k = 0; k < 400 && exp_q.size() > 0; k++) @(posedge clk);
        if (exp_q.size() > 0) begin
            checks++; failures++;
            $display("FAIL timeout: request len=%0d still pending, expected completion", len);
            exp_q.delete();
        end
        lat = done_cyc - t0;
        err = done_err;
    endtask

    task automatic stimulus();
        int         lat;
        logic       err;
        int         w0;
        int         dc;
        int         pos;
        int         bad;
        logic [7:0] b;

        rst = 1'b1; start = 1'b0; block_length = 8'd0; block_address = 16'd0; block_type = 8'd0;
        for (int i = 0; i < MAXB; i++) block_data[i] = 8'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_ready", ready, 1);
        chk("reset_used", prog_used, 0);
        chk("reset_we", prog_we, 0);
        chk("reset_done", done, 0);

        // Block 1: L=16 at 0x1234, data 0x10+i
        run_block(16, 16'h1234, 8'h00, 8'h10, lat, err);
        #1;
        chk("b1_latency", lat, 22);
        chk("b1_error", err, 0);
        chk("b1_used", prog_used, 20);
        chk("b1_ram0", ram[0], 8'h10);
        chk("b1_ram1", ram[1], 8'h12);
        chk("b1_ram2", ram[2], 8'h34);
        chk("b1_ram3", ram[3], 8'h00);
        chk("b1_ram4", ram[4], 8'h10);
        chk("b1_ram19", ram[19], 8'h1F);

        // Block 2 starts the cycle ready returns
        run_block(16, 16'h5678, 8'h00, 8'h20, lat, err);
        #1;
        chk("b2_latency", lat, 22);
        chk("b2_used", prog_used, 40);
        chk("b2_ram20", ram[20], 8'h10);
        chk("b2_ram21", ram[21], 8'h56);
        chk("b2_ram22", ram[22], 8'h78);
        chk("b2_ram39", ram[39], 8'h2F);

        // Walk the image as the decoder would
        pos = 0;
        for (int blk = 0; blk < 2; blk++) begin
            b = (blk == 0) ? 8'h10 : 8'h20;
            chk("replay_len", ram[pos], 16);
            chk("replay_addr", {ram[pos+1], ram[pos+2]}, (blk == 0) ? 16'h1234 : 16'h5678);
            bad = 0;
            for (int i = 0; i < 16; i++) if (ram[pos+4+i] !== b + 8'(i)) bad++;
            chk("replay_data_bad", bad, 0);
            pos = pos + 4 + int'(ram[pos]);
        end

        // Overflow by one byte: 40+4+21 = 65
        w0 = wr_count;
        run_block(21, 16'h9999, 8'h01, 8'h30, lat, err);
        #1;
        chk("ovf_latency", lat, 2);
        chk("ovf_error", err, 1);
        chk("ovf_writes", wr_count - w0, 0);
        chk("ovf_used", prog_used, 40);

        // Length above maximum payload
        w0 = wr_count;
        run_block(33, 16'h4242, 8'h01, 8'h30, lat, err);
        #1;
        chk("maxlen_latency", lat, 2);
        chk("maxlen_error", err, 1);
        chk("maxlen_writes", wr_count - w0, 0);

        // Exact fit: 40+4+20 = 64
        run_block(20, 16'h0A0B, 8'h02, 8'h40, lat, err);
        #1;
        chk("fit_latency", lat, 26);
        chk("fit_error", err, 0);
        chk("fit_used", prog_used, 64);
        chk("fit_ram40", ram[40], 8'h14);
        chk("fit_ram63", ram[63], 8'h53);

        // Full RAM: even an empty block does not fit
        run_block(0, 16'h0000, 8'hFF, 8'h00, lat, err);
        #1;
        chk("full_error", err, 1);
        chk("full_used", prog_used, 64);

        // Reset clears the pointer
        rst = 1'b1;
        @(posedge clk);
        model_used = 0;
        #1 rst = 1'b0;

        // End marker: L=0
        w0 = wr_count;
        run_block(0, 16'hABCD, 8'hFF, 8'h00, lat, err);
        #1;
        chk("eop_latency", lat, 6);
        chk("eop_writes", wr_count - w0, 4);
        chk("eop_ram0", ram[0], 8'h00);
        chk("eop_ram1", ram[1], 8'hAB);
        chk("eop_ram2", ram[2], 8'hCD);
        chk("eop_ram3", ram[3], 8'hFF);
        chk("eop_ram4_untouched", ram[4], 8'h10);
        chk("eop_used", prog_used, 4);

        // Reset during DATA, with an ignored start while busy
        #1;
        start = 1'b1; block_length = 8'd16; block_address = 16'h1111; block_type = 8'h03;
        for (int i = 0; i < MAXB; i++) block_data[i] = 8'h60 + 8'(i);
        @(posedge clk);
        model_request(16, 16'h1111, 8'h03, 8'h60);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #1 start = 1'b1; block_length = 8'd0;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (6) @(posedge clk);
        #1 rst = 1'b1;
        dc = done_cnt;
        @(posedge clk);
        exp_q.delete();
        model_used = 0;
        #1 rst = 1'b0;
        chk("abort_ready", ready, 1);
        chk("abort_used", prog_used, 0);
        chk("abort_we", prog_we, 0);
        repeat (30) @(posedge clk);
        chk("abort_no_done", done_cnt - dc, 0);
        chk("abort_ram8", ram[8], 8'h60);
        chk("abort_ram12", ram[12], 8'h64);
        chk("abort_ram13_kept", ram[13], 8'h19);

        // Normal operation after the abort
        run_block(2, 16'h0102, 8'h05, 8'h70, lat, err);
        #1;
        chk("post_latency", lat, 8);
        chk("post_used", prog_used, 6);
        chk("post_ram5", ram[5], 8'h71);
    endtask

    initial begin
        checks = 0; failures = 0; ncyc = 0; done_cyc = 0; done_err = 1'b0;
        done_cnt = 0; wr_count = 0; model_used = 0;
        for (int i = 0; i < PSIZE; i++) ram[i] = 8'h00;
        fork
            compare_loop();
            stimulus();
        join_any
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/program_encoder.md
# program_encoder

Serialises data blocks into the byte-oriented program image format that `program_decoder` consumes, writing them sequentially into a program RAM. Each `start` appends one block (4-byte header plus payload) at the current write pointer, so successive blocks form a contiguous image. Used to build program images on-chip, for example from a host link or a capture path, before they are replayed by the decoder/UPDI side.

## Interface
Parameters:
- `PROGRAM_SIZE`, 64: program RAM size in bytes.
- `DATA_BLOCK_MAX_SIZE`, 32: maximum payload bytes per block.
- `PROG_ADDR_BITS`, `$clog2(PROGRAM_SIZE)`: derived; RAM address width.

Ports:
- `clk`  in  1  single clock; all logic on posedge.
- `rst`  in  1  reset, synchronous and active-high.
- `start`  in  1  request to encode one block; sampled only while `ready`.
- `block_length`  in  8  payload byte count L, 0..255.
- `block_address`  in  16  target address stored in the header.
- `block_type`  in  8  block type byte.
- `block_data`  in  8 x `DATA_BLOCK_MAX_SIZE`  unpacked payload array; entries at index L and above are ignored.
- `ready`  out  1  idle and able to accept `start`.
- `done`  out  1  one-cycle pulse when a request finishes, whether it succeeded or failed.
- `error`  out  1  one-cycle pulse together with `done` when a request is rejected.
- `prog_we`  out  1  RAM write enable.
- `prog_addr`  out  `PROG_ADDR_BITS`  RAM write address.
- `prog_wdata`  out  8  RAM write data.
- `prog_used`  out  `PROG_ADDR_BITS+1`  bytes written so far; this is the write pointer.

## Operation
- Block image format (shared with `program_decoder`): byte 0 = length L, byte 1 = address[15:8], byte 2 = address[7:0], byte 3 = type, bytes 4..4+L-1 = data[0..L-1].
- On the cycle `start` is accepted, the block inputs are latched. Later changes to the inputs have no effect on the request in progress.
- Validation is done on the latched values. A request is rejected if L > `DATA_BLOCK_MAX_SIZE` or if `prog_used` + 4 + L > `PROGRAM_SIZE`. The comparison uses at least 10-bit arithmetic, so no wrap occurs.
- A rejected request performs no writes and leaves `prog_used` unchanged.
- L = 0 is legal. It writes the 4 header bytes only, and is used as an end-of-program marker.
- State machine: IDLE -> (start & ready) -> CHECK -> HDR_LEN -> HDR_AHI -> HDR_ALO -> HDR_TYPE -> DATA (L cycles; skipped when L=0) -> FIN -> IDLE.
- On a failed check, CHECK -> FIN with the error flag set.
- Each HDR_* and DATA cycle drives `prog_we`=1 with `prog_addr` = `prog_used` and the corresponding byte. `prog_used` then increments by 1 on that clock edge.
- FIN asserts `done` (and `error` if the request was rejected) for one cycle. `ready` is 0 during FIN.
- `prog_used` is cleared only by `rst`. It never wraps, because the overflow check guarantees `prog_used` ≤ `PROGRAM_SIZE`.

## Timing
- Reset values: state IDLE, `ready`=1, `done`=0, `error`=0, `prog_we`=0, `prog_addr`=0, `prog_wdata`=0, `prog_used`=0.
- All outputs are registered.
- The RAM captures `prog_addr`/`prog_wdata` on any clock edge where `prog_we`=1. The RAM may sample on negedge, as the decoder ROM does.
- Cycle timing, with cycle 0 being the edge on which `start` is sampled:
  - Cycle 1: CHECK. `ready`=0, no write.
  - Cycles 2..5: header writes.
  - Cycles 6..5+L: data writes.
  - Cycle 6+L: `done`.
  - Cycle 7+L: `ready`=1.
- Total latency from start to done is 6+L cycles. A rejected request reaches `done`+`error` at cycle 2.
- `start` while `ready`=0 is ignored, with no queuing.
- `start` in the same cycle as `ready` returning is accepted.
- `rst` asserted mid-request aborts immediately. The next edge applies the reset values, bytes already written remain in the RAM, and no `done` is produced.

## Test plan
- Reset, then a block with L=16, address 0x1234, type 0x00, data[i]=0x10+i -> writes to addresses 0..19: 0x10,0x12,0x34,0x00,0x10..0x1F. `done` at cycle 22, `prog_used`=20. Replaying the RAM through `program_decoder` returns the same block.
- Second block with L=16, address 0x5678, data[i]=0x20+i -> writes to addresses 20..39 with header 0x10,0x56,0x78,0x00. `prog_used`=40. The decoder then yields both blocks in order.
- Block with L=0, type 0xFF -> exactly 4 writes (0x00,addr_hi,addr_lo,0xFF), no data writes. `done` at cycle 6.
- With `prog_used`=40 and `PROGRAM_SIZE`=64, L=21 (needs 25 bytes) -> `done`+`error` at cycle 2, no `prog_we`, `prog_used` stays 40. L=20 (needs exactly 24) -> accepted, `prog_used`=64.
- L=33 with `DATA_BLOCK_MAX_SIZE`=32 -> rejected with `error`, no writes.
- Assert `rst` during the DATA state of a 16-byte block -> next cycle `ready`=1, `prog_used`=0, `prog_we`=0, no `done`. A `start` pulse during busy cycles is also ignored.
